// File: rtl/rx_phase_sampler_pkg.sv
// rtl/rx_phase_sampler_pkg.sv - shared defaults, state encoding and width helper for rx_phase_sampler
// Purpose: default parameter values, ACQ/LOCK state type and accumulator width helper.
// Ports: none (package).
package rx_phase_sampler_pkg;

   localparam int NB_DATA_DEF  = 8;
   localparam int OS_DEF       = 4;
   localparam int LOG2_WIN_DEF = 7;
   localparam int LOCK_CNT_DEF = 3;

   // Phase index width; o_phase is a fixed 2-bit port.
   localparam int PH_W = 2;

   typedef enum logic {
      ST_ACQ  = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   // Magnitude is NB_DATA-1 bits; 2^LOG2_WIN additions of it cannot overflow this width.
   function automatic int nb_acc(input int nb_data, input int log2_win);
      return nb_data - 1 + log2_win;
   endfunction

endpackage

// File: rtl/rx_phase_sampler_phase_argmax.sv
// rtl/rx_phase_sampler_phase_argmax.sv - combinational argmax over the per-phase energy accumulators
// Purpose: returns the index of the largest accumulator; ties resolve to the lowest index.
// Ports:
//   acc_i  in   OS x NB_ACC  packed accumulator values, index 0 in the low slice
//   idx_o  out  PH_W         winning phase index
module rx_phase_sampler_phase_argmax
   import rx_phase_sampler_pkg::*;
#(
   parameter int OS     = OS_DEF,
   parameter int NB_ACC = nb_acc(NB_DATA_DEF, LOG2_WIN_DEF)
) (
   input  logic [OS-1:0][NB_ACC-1:0] acc_i,
   output logic [PH_W-1:0]           idx_o
);

   logic [NB_ACC-1:0] best;

   // Strict greater-than keeps the earlier (lower) index on equal values.
   always_comb begin
      best  = acc_i[0];
      idx_o = '0;
      for (int p = 1; p < OS; p++) begin
         if (acc_i[p] > best) begin
            best  = acc_i[p];
            idx_o = PH_W'(p);
         end
      end
   end

endmodule

// File: rtl/rx_phase_sampler.sv
// rtl/rx_phase_sampler.sv - max-energy sampling phase selection and 1-bit-per-symbol decimation
// Purpose: accumulates |x| per oversampling phase over 2^LOG2_WIN symbols, selects the strongest
//   phase at each window end, tracks ACQ/LOCK and emits the sign of the sample at the chosen phase.
// Optional feature macro: RX_PHASE_SAMPLER_MANUAL_EN (adds i_auto / i_phase_manual override).
// Ports:
//   clock           in   1        system clock
//   i_reset         in   1        synchronous active-high reset
//   i_data          in   NB_DATA  signed sample, one per clock
//   i_valid         in   1        symbol strobe, marks phase 0
//   i_enable        in   1        0 freezes all state and suppresses output
//   i_auto          in   1        (macro only) 0 = manual phase
//   i_phase_manual  in   2        (macro only) phase used when i_auto=0
//   o_bit           out  1        hard decision, 1 = negative sample
//   o_valid         out  1        one strobe per symbol qualifying o_bit
//   o_phase         out  2        selected phase
//   o_locked        out  1        phase stable for LOCK_CNT windows
module rx_phase_sampler
   import rx_phase_sampler_pkg::*;
#(
   parameter int NB_DATA  = NB_DATA_DEF,
   parameter int OS       = OS_DEF,
   parameter int LOG2_WIN = LOG2_WIN_DEF,
   parameter int LOCK_CNT = LOCK_CNT_DEF
) (
   input  logic               clock,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_data,
   input  logic               i_valid,
   input  logic               i_enable,
`ifdef RX_PHASE_SAMPLER_MANUAL_EN
   input  logic               i_auto,
   input  logic [1:0]         i_phase_manual,
`endif
   output logic               o_bit,
   output logic               o_valid,
   output logic [1:0]         o_phase,
   output logic               o_locked
);

   localparam int NB_ACC = nb_acc(NB_DATA, LOG2_WIN);
   localparam int WC_W   = LOG2_WIN + 1;
   localparam int SC_W   = $clog2(LOCK_CNT + 1);
   localparam logic [WC_W-1:0] WIN_LEN = {1'b1, {LOG2_WIN{1'b0}}};

   logic [PH_W-1:0]              phase_q;
   logic [WC_W-1:0]              win_cnt_q;
   logic [OS-1:0][NB_ACC-1:0]    acc_q;
   logic [SC_W-1:0]              stable_cnt_q;
   state_t                       state_q;
   logic                         o_bit_q;
   logic                         o_valid_q;
   logic [PH_W-1:0]              o_phase_q;

   logic [PH_W-1:0]              phase_d;
   logic [NB_DATA-1:0]           abs_full;
   logic [NB_DATA-2:0]           mag;
   logic [PH_W-1:0]              winner;
   logic                         win_end;

   // Phase of the sample on the input this cycle; also the next counter value.
   always_comb begin
      if (i_valid || (phase_q == PH_W'(OS - 1))) phase_d = '0;
      else                                       phase_d = phase_q + 1'b1;
   end

   // Only the most negative input leaves the MSB set after negation; clamp it to max positive.
   always_comb begin
      abs_full = i_data[NB_DATA-1] ? (~i_data + 1'b1) : i_data;
      mag      = abs_full[NB_DATA-1] ? {(NB_DATA-1){1'b1}} : abs_full[NB_DATA-2:0];
   end

   // Window closes on the first phase-0 sample after 2^LOG2_WIN counted symbols.
   assign win_end = i_enable && (phase_d == '0) && (win_cnt_q == WIN_LEN);

   rx_phase_sampler_phase_argmax #(
      .OS     (OS),
      .NB_ACC (NB_ACC)
   ) u_argmax (
      .acc_i (acc_q),
      .idx_o (winner)
   );

   always_ff @(posedge clock) begin
      if (i_reset) begin
         phase_q      <= '0;
         win_cnt_q    <= '0;
         acc_q        <= '0;
         stable_cnt_q <= '0;
         state_q      <= ST_ACQ;
         o_bit_q      <= 1'b0;
         o_valid_q    <= 1'b0;
         o_phase_q    <= '0;
      end else begin
         if (i_enable) begin
            phase_q <= phase_d;
            // On window end the cleared accumulator still takes this cycle's sample.
            for (int p = 0; p < OS; p++) begin
               acc_q[p] <= (win_end ? '0 : acc_q[p])
                         + ((phase_d == PH_W'(p)) ? NB_ACC'(mag) : '0);
            end
            if (phase_d == '0) win_cnt_q <= win_end ? WC_W'(1) : win_cnt_q + 1'b1;
            o_valid_q <= (phase_d == o_phase_q);
            if (phase_d == o_phase_q) o_bit_q <= i_data[NB_DATA-1];
            if (win_end) begin
               o_phase_q <= winner;
               case (state_q)
                  ST_ACQ: begin
                     if (winner == o_phase_q) begin
                        if (stable_cnt_q == SC_W'(LOCK_CNT - 1)) begin
                           state_q      <= ST_LOCK;
                           stable_cnt_q <= '0;
                        end else begin
                           stable_cnt_q <= stable_cnt_q + 1'b1;
                        end
                     end else begin
                        stable_cnt_q <= '0;
                     end
                  end
                  ST_LOCK: begin
                     if (winner != o_phase_q) begin
                        state_q      <= ST_ACQ;
                        stable_cnt_q <= '0;
                     end
                  end
                  default: state_q <= ST_ACQ;
               endcase
            end
         end else begin
            o_valid_q <= 1'b0;
         end
`ifdef RX_PHASE_SAMPLER_MANUAL_EN
         // Manual phase overrides the winner every clock; energy tracking keeps running.
         if (!i_auto) o_phase_q <= i_phase_manual;
`endif
      end
   end

   assign o_bit   = o_bit_q;
   assign o_valid = o_valid_q;
   assign o_phase = o_phase_q;
`ifdef RX_PHASE_SAMPLER_MANUAL_EN
   assign o_locked = (state_q == ST_LOCK) && i_auto;
`else
   assign o_locked = (state_q == ST_LOCK);
`endif

endmodule

// File: tb/tb_rx_phase_sampler.sv
// tb/tb_rx_phase_sampler.sv - directed table and window-sequence bench for rx_phase_sampler
module tb_rx_phase_sampler;

   logic       clock = 1'b0;
   logic       i_reset;
   logic [7:0] i_data;
   logic       i_valid;
   logic       i_enable;
   logic       o_bit;
   logic       o_valid;
   logic [1:0] o_phase;
   logic       o_locked;
`ifdef RX_PHASE_SAMPLER_MANUAL_EN
   logic       i_auto;
   logic [1:0] i_phase_manual;
`endif

   always #5 clock = ~clock;

   rx_phase_sampler dut (
      .clock          (clock),
      .i_reset        (i_reset),
      .i_data         (i_data),
      .i_valid        (i_valid),
      .i_enable       (i_enable),
`ifdef RX_PHASE_SAMPLER_MANUAL_EN
      .i_auto         (i_auto),
      .i_phase_manual (i_phase_manual),
`endif
      .o_bit          (o_bit),
      .o_valid        (o_valid),
      .o_phase        (o_phase),
      .o_locked       (o_locked)
   );

   int         n_vec = 0;
   int         n_bad = 0;
   logic [1:0] m_phase;

   typedef struct {
      logic       v;
      logic       en;
      logic [7:0] d;
      logic       ev;
      logic       eb;
   } vec_t;

   vec_t vt [17];

   logic [3:0][7:0] t1, t2, t4, t5, t6;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change just after a negedge; outputs are sampled at the following negedge.
   task automatic step(input logic [7:0] d, input logic v, input logic en);
      i_data   = d;
      i_valid  = v;
      i_enable = en;
      @(negedge clock);
   endtask

   // One symbol of four samples. With chk set, the phase-0 sample closes a window and the
   // selected phase / lock flag are checked against ph / lk. With gap set, 50 disabled cycles
   // of full-scale negative samples are inserted after phase 1.
   task automatic send_sym(input logic [3:0][7:0] d, input bit chk, input logic [1:0] ph,
                           input bit lk, input bit gap);
      logic ev;
      for (int p = 0; p < 4; p++) begin
         step(d[p], (p == 0), 1'b1);
         ev = (2'(p) == m_phase);
         check("o_valid", o_valid, ev);
         if (ev) check("o_bit", o_bit, d[p][7]);
         if (p == 0 && chk) begin
            check("o_phase", o_phase, ph);
            check("o_locked", o_locked, lk);
            m_phase = ph;
         end
         if (p == 1 && gap) begin
            for (int k = 0; k < 50; k++) begin
               step(8'h80, (k % 7 == 0), 1'b0);
               check("o_valid_disabled", o_valid, 1'b0);
            end
         end
      end
   endtask

   task automatic run_window(input logic [3:0][7:0] d, input bit chk, input logic [1:0] ph,
                             input bit lk, input bit gap);
      for (int s = 0; s < 128; s++)
         send_sym(d, chk && (s == 0), ph, lk, gap && (s == 64));
   endtask

   task automatic check_reset_state();
      check("rst_o_bit", o_bit, 1'b0);
      check("rst_o_valid", o_valid, 1'b0);
      check("rst_o_phase", o_phase, 2'd0);
      check("rst_o_locked", o_locked, 1'b0);
   endtask

   initial begin
      // Output path with o_phase=0: {valid, enable, data, expected o_valid, expected o_bit}
      vt[0]  = '{1'b1, 1'b1, 8'hFB, 1'b1, 1'b1};  // phase 0, -5
      vt[1]  = '{1'b0, 1'b1, 8'd7,  1'b0, 1'b1};  // phase 1
      vt[2]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b1};  // phase 2
      vt[3]  = '{1'b0, 1'b1, 8'd3,  1'b0, 1'b1};  // phase 3
      vt[4]  = '{1'b1, 1'b1, 8'd20, 1'b1, 1'b0};  // phase 0, +20
      vt[5]  = '{1'b1, 1'b0, 8'hCE, 1'b0, 1'b0};  // disabled, strobe ignored
      vt[6]  = '{1'b0, 1'b0, 8'hCE, 1'b0, 1'b0};  // disabled
      vt[7]  = '{1'b0, 1'b1, 8'hFD, 1'b0, 1'b0};  // phase 1
      vt[8]  = '{1'b1, 1'b1, 8'h80, 1'b1, 1'b1};  // early strobe resyncs to phase 0
      vt[9]  = '{1'b0, 1'b1, 8'h7F, 1'b0, 1'b1};  // phase 1
      vt[10] = '{1'b0, 1'b1, 8'd0,  1'b0, 1'b1};  // phase 2
      vt[11] = '{1'b0, 1'b1, 8'd0,  1'b0, 1'b1};  // phase 3
      vt[12] = '{1'b0, 1'b1, 8'd5,  1'b1, 1'b0};  // wrap to phase 0 without strobe
      vt[13] = '{1'b0, 1'b1, 8'hF7, 1'b0, 1'b0};  // phase 1
      vt[14] = '{1'b0, 1'b1, 8'hF7, 1'b0, 1'b0};  // phase 2
      vt[15] = '{1'b0, 1'b1, 8'hF7, 1'b0, 1'b0};  // phase 3
      vt[16] = '{1'b0, 1'b1, 8'hFB, 1'b1, 1'b1};  // phase 0, -5

      t1 = {8'd10, 8'd100, 8'd10, 8'd10};   // peak at phase 2
      t4 = {8'd0, 8'd0, 8'h80, 8'd0};       // -128 at phase 1
      t5 = {8'd100, 8'hD8, 8'd30, 8'hEC};   // -20, 30, -40, 100: peak at phase 3
      t2 = {8'hCE, 8'd50, 8'hCE, 8'd50};    // equal magnitude everywhere
      t6 = {8'd10, 8'hD8, 8'd10, 8'd10};    // -40 at phase 2

`ifdef RX_PHASE_SAMPLER_MANUAL_EN
      i_auto         = 1'b1;
      i_phase_manual = 2'd0;
`endif
      i_reset = 1'b1;
      i_data  = '0;
      i_valid = 1'b0;
      i_enable = 1'b0;
      @(negedge clock);
      step(8'd0, 1'b0, 1'b0);
      check_reset_state();
      i_reset = 1'b0;

      for (int i = 0; i < 17; i++) begin
         step(vt[i].d, vt[i].v, vt[i].en);
         check($sformatf("vec%0d_o_valid", i), o_valid, vt[i].ev);
         check($sformatf("vec%0d_o_bit", i), o_bit, vt[i].eb);
      end

      // Reset in the middle of a partial window clears outputs on the next edge.
      i_reset = 1'b1;
      step(8'h80, 1'b1, 1'b1);
      check_reset_state();
      i_reset = 1'b0;
      m_phase = 2'd0;

      // Peak at phase 2: selected after window 1, lock after three further equal windows.
      run_window(t1, 1'b0, 2'd0, 1'b0, 1'b0);
      run_window(t1, 1'b1, 2'd2, 1'b0, 1'b0);
      run_window(t1, 1'b1, 2'd2, 1'b0, 1'b0);
      run_window(t1, 1'b1, 2'd2, 1'b0, 1'b0);
      // Saturating -128 at phase 1: lock is lost on the jump, new phase applied, relock.
      run_window(t4, 1'b1, 2'd2, 1'b1, 1'b0);
      run_window(t4, 1'b1, 2'd1, 1'b0, 1'b0);
      run_window(t4, 1'b1, 2'd1, 1'b0, 1'b0);
      run_window(t4, 1'b1, 2'd1, 1'b0, 1'b0);
      // Peak moves from phase 1 to phase 3.
      run_window(t5, 1'b1, 2'd1, 1'b1, 1'b0);
      run_window(t5, 1'b1, 2'd3, 1'b0, 1'b0);
      run_window(t5, 1'b1, 2'd3, 1'b0, 1'b0);
      run_window(t5, 1'b1, 2'd3, 1'b0, 1'b0);
      // Equal magnitudes: tie resolves to phase 0.
      run_window(t2, 1'b1, 2'd3, 1'b1, 1'b0);
      run_window(t2, 1'b1, 2'd0, 1'b0, 1'b0);
      run_window(t2, 1'b1, 2'd0, 1'b0, 1'b0);
      run_window(t2, 1'b1, 2'd0, 1'b0, 1'b0);
      // Window with 50 disabled full-scale cycles mid-symbol; if they leaked into phase 1
      // its energy would exceed phase 2's.
      run_window(t6, 1'b1, 2'd0, 1'b1, 1'b1);
      for (int s = 0; s < 10; s++) send_sym(t6, (s == 0), 2'd2, 1'b0, 1'b0);

      // Mid-window reset after a negative decision.
      check("pre_reset_o_bit", o_bit, 1'b1);
      i_reset = 1'b1;
      step(8'h80, 1'b1, 1'b1);
      check_reset_state();
      i_reset = 1'b0;
      m_phase = 2'd0;
      run_window(t4, 1'b0, 2'd0, 1'b0, 1'b0);
      send_sym(t4, 1'b1, 2'd1, 1'b0, 1'b0);

`ifdef RX_PHASE_SAMPLER_MANUAL_EN
      i_auto         = 1'b0;
      i_phase_manual = 2'd3;
      step(8'd0, 1'b0, 1'b1);
      check("manual_o_phase", o_phase, 2'd3);
      check("manual_o_locked", o_locked, 1'b0);
      i_auto = 1'b1;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
